// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone classic (single-beat) arbiter: N_MST masters share one
// slave port. One registered grant per transaction, released on slave ack or
// master abort. The rotation pointer makes the last-served master rank lowest.
// Optional feature: define WB_ARB_TIMEOUT_EN to terminate grants whose slave
// never acks after TIMEOUT busy cycles, returning 32'hDEAD_BEEF with a pulse
// on tout_o.
module wb_rr_arbiter #(
    parameter int N_MST   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_MST-1:0]     m_cyc_i,
    input  logic [N_MST-1:0]     m_stb_i,
    input  logic [N_MST-1:0]     m_we_i,
    input  logic [4*N_MST-1:0]   m_sel_i,
    input  logic [32*N_MST-1:0]  m_adr_i,
    input  logic [32*N_MST-1:0]  m_wdat_i,
    output logic [N_MST-1:0]     m_ack_o,
    output logic [31:0]          m_rdat_o,
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    output logic                 s_we_o,
    output logic [3:0]           s_sel_o,
    output logic [31:0]          s_adr_o,
    output logic [31:0]          s_wdat_o,
    input  logic                 s_ack_i,
    input  logic [31:0]          s_rdat_i,
    output logic [N_MST-1:0]     gnt_o,
    output logic                 tout_o
);

    localparam int             IW        = (N_MST > 1) ? $clog2(N_MST) : 1;
    localparam int             LAST_INIT = N_MST - 1;
    localparam logic [IW:0]    N_L       = N_MST[IW:0];
    localparam logic [IW:0]    ONE_L     = {{IW{1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              state_r;
    logic [N_MST-1:0]    gnt_r;
    logic [IW-1:0]       last_r;

    logic [N_MST-1:0]    req_s;
    logic                found_s;
    logic [IW-1:0]       nxt_idx_s;
    logic [IW:0]         cand_s;
    logic [N_MST-1:0]    nxt_gnt_s;

    logic                gcyc_s;
    logic                gstb_s;
    logic                gwe_s;
    logic [3:0]          gsel_s;
    logic [31:0]         gadr_s;
    logic [31:0]         gwdat_s;
    logic                tout_s;

    assign req_s     = m_cyc_i & m_stb_i;
    assign nxt_gnt_s = {{(N_MST-1){1'b0}}, 1'b1} << nxt_idx_s;

    // Pick the first requester scanning upward from last+1 with wrap-around.
    always_comb begin
        found_s   = 1'b0;
        nxt_idx_s = last_r;
        cand_s    = {1'b0, last_r};
        for (int i = 0; i < N_MST; i++) begin
            cand_s = cand_s + ONE_L;
            if (cand_s >= N_L) begin
                cand_s = cand_s - N_L;
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && req_s[cand_s[IW-1:0]]) begin
                found_s   = 1'b1;
                nxt_idx_s = cand_s[IW-1:0];
            end else begin
                found_s   = found_s;
            end
        end
    end

    // AND-OR mux of the granted master's request; all zero while no grant is held.
    always_comb begin
        gcyc_s  = 1'b0;
        gstb_s  = 1'b0;
        gwe_s   = 1'b0;
        gsel_s  = 4'h0;
        gadr_s  = 32'h0000_0000;
        gwdat_s = 32'h0000_0000;
        for (int k = 0; k < N_MST; k++) begin
            gcyc_s  = gcyc_s  | (m_cyc_i[k] & gnt_r[k]);
            gstb_s  = gstb_s  | (m_stb_i[k] & gnt_r[k]);
            gwe_s   = gwe_s   | (m_we_i[k]  & gnt_r[k]);
            gsel_s  = gsel_s  | (m_sel_i[4*k +: 4]   & {4{gnt_r[k]}});
            gadr_s  = gadr_s  | (m_adr_i[32*k +: 32]  & {32{gnt_r[k]}});
            gwdat_s = gwdat_s | (m_wdat_i[32*k +: 32] & {32{gnt_r[k]}});
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int          TW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TOUT_L = TIMEOUT[TW-1:0];

    logic [TW-1:0] cnt_r;

    // Count busy cycles without ack; held at zero while idle so each grant starts fresh.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r <= {TW{1'b0}};
        end else if (state_r != BUSY) begin
            cnt_r <= {TW{1'b0}};
        end else if (!s_ack_i && (cnt_r != TOUT_L)) begin
            cnt_r <= cnt_r + {{(TW-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tout_s = (state_r == BUSY) & gcyc_s & ~s_ack_i & (cnt_r == TOUT_L);
`else
    assign tout_s = 1'b0;
`endif

    // Grant FSM: register the winner in IDLE, release on ack, abort or timeout.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            gnt_r   <= {N_MST{1'b0}};
            last_r  <= LAST_INIT[IW-1:0];
        end else begin
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        state_r <= BUSY;
                        gnt_r   <= nxt_gnt_s;
                        last_r  <= nxt_idx_s;
                    end else begin
                        state_r <= IDLE;
                        gnt_r   <= {N_MST{1'b0}};
                        last_r  <= last_r;
                    end
                end
                BUSY: begin
                    if (s_ack_i || !gcyc_s || tout_s) begin
                        state_r <= IDLE;
                        gnt_r   <= {N_MST{1'b0}};
                    end else begin
                        state_r <= BUSY;
                        gnt_r   <= gnt_r;
                    end
                    last_r <= last_r;
                end
                default: begin
                    state_r <= IDLE;
                    gnt_r   <= {N_MST{1'b0}};
                    last_r  <= last_r;
                end
            endcase
        end
    end

    // A timeout cycle hides the request from the slave while faking the completion.
    assign s_cyc_o  = gcyc_s & ~tout_s;
    assign s_stb_o  = gstb_s & ~tout_s;
    assign s_we_o   = gwe_s;
    assign s_sel_o  = gsel_s;
    assign s_adr_o  = gadr_s;
    assign s_wdat_o = gwdat_s;

    assign m_ack_o  = gnt_r & {N_MST{s_ack_i | tout_s}};
    assign m_rdat_o = tout_s ? 32'hDEAD_BEEF : s_rdat_i;
    assign gnt_o    = gnt_r;
    assign tout_o   = tout_s;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed, table-driven bench for wb_rr_arbiter (4 masters, TIMEOUT=8).
// Master k drives a fixed request pattern so the slave-side mux can be
// predicted from the expected grant index alone.
module tb_wb_rr_arbiter;

    localparam int NM = 4;

    logic              clk;
    logic              rst;
    logic [NM-1:0]     m_cyc;
    logic [NM-1:0]     m_stb;
    logic [NM-1:0]     m_we;
    logic [4*NM-1:0]   m_sel;
    logic [32*NM-1:0]  m_adr;
    logic [32*NM-1:0]  m_wdat;
    logic [NM-1:0]     m_ack;
    logic [31:0]       m_rdat;
    logic              s_cyc;
    logic              s_stb;
    logic              s_we;
    logic [3:0]        s_sel;
    logic [31:0]       s_adr;
    logic [31:0]       s_wdat;
    logic              s_ack;
    logic [31:0]       s_rdat;
    logic [NM-1:0]     gnt;
    logic              tout;

    int n_checks = 0;
    int n_err    = 0;

    wb_rr_arbiter #(.N_MST(NM), .TIMEOUT(8)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .m_cyc_i  (m_cyc),
        .m_stb_i  (m_stb),
        .m_we_i   (m_we),
        .m_sel_i  (m_sel),
        .m_adr_i  (m_adr),
        .m_wdat_i (m_wdat),
        .m_ack_o  (m_ack),
        .m_rdat_o (m_rdat),
        .s_cyc_o  (s_cyc),
        .s_stb_o  (s_stb),
        .s_we_o   (s_we),
        .s_sel_o  (s_sel),
        .s_adr_o  (s_adr),
        .s_wdat_o (s_wdat),
        .s_ack_i  (s_ack),
        .s_rdat_i (s_rdat),
        .gnt_o    (gnt),
        .tout_o   (tout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  cyc;
        logic        ack;
        logic [31:0] rdat;
        logic [3:0]  e_gnt;
        logic [3:0]  e_ack;
        logic        e_scyc;
        int          e_mst;
    } vec_t;

    localparam int NV = 32;
    vec_t vt [NV];

    function automatic logic [31:0] adr_of(input int k);
        logic [31:0] kv;
        kv = k;
        return 32'h1000_0000 | (kv << 8);
    endfunction

    function automatic logic [31:0] wdat_of(input int k);
        logic [31:0] kv;
        kv = k;
        return 32'hA0A0_0000 | kv;
    endfunction

    function automatic logic [3:0] sel_of(input int k);
        logic [31:0] kv;
        kv = k;
        return kv[3:0] + 4'd1;
    endfunction

    function automatic logic we_of(input int k);
        logic [31:0] kv;
        kv = k;
        return kv[0];
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got %h expected %h", nm, idx, got, exp);
        end
    endtask

    // Compare every output against the expectation for one cycle.
    task automatic chk_all(input int idx, input logic [3:0] e_gnt, input logic [3:0] e_ack,
                           input logic e_scyc, input int e_mst, input logic [31:0] e_rdat,
                           input logic e_tout);
        logic [31:0] ea, ew;
        logic [3:0]  es;
        logic        ewe;
        if (e_mst >= 0) begin
            ea = adr_of(e_mst); ew = wdat_of(e_mst); es = sel_of(e_mst); ewe = we_of(e_mst);
        end else begin
            ea = 32'h0; ew = 32'h0; es = 4'h0; ewe = 1'b0;
        end
        chk("gnt",    idx, {28'h0, gnt},    {28'h0, e_gnt});
        chk("m_ack",  idx, {28'h0, m_ack},  {28'h0, e_ack});
        chk("s_cyc",  idx, {31'h0, s_cyc},  {31'h0, e_scyc});
        chk("s_stb",  idx, {31'h0, s_stb},  {31'h0, e_scyc});
        chk("s_adr",  idx, s_adr,  ea);
        chk("s_wdat", idx, s_wdat, ew);
        chk("s_sel",  idx, {28'h0, s_sel},  {28'h0, es});
        chk("s_we",   idx, {31'h0, s_we},   {31'h0, ewe});
        chk("m_rdat", idx, m_rdat, e_rdat);
        chk("tout",   idx, {31'h0, tout},   {31'h0, e_tout});
    endtask

    task automatic drive(input logic r, input logic [3:0] c, input logic a, input logic [31:0] d);
        rst    = r;
        m_cyc  = c;
        m_stb  = c;
        s_ack  = a;
        s_rdat = d;
    endtask

    initial begin
        // Fixed per-master request contents.
        for (int k = 0; k < NM; k++) begin
            m_adr[32*k +: 32]  = adr_of(k);
            m_wdat[32*k +: 32] = wdat_of(k);
            m_sel[4*k +: 4]    = sel_of(k);
            m_we[k]            = we_of(k);
        end
        drive(1'b1, 4'b0000, 1'b0, 32'h0);

        //          rst   cyc      ack   rdat           e_gnt    e_ack    scyc  mst
        // master 2 single read
        vt[0]  = '{1'b0, 4'b0100, 1'b0, 32'h0,         4'b0000, 4'b0000, 1'b0, -1};
        vt[1]  = '{1'b0, 4'b0100, 1'b0, 32'h0,         4'b0100, 4'b0000, 1'b1,  2};
        vt[2]  = '{1'b0, 4'b0100, 1'b1, 32'h1234_5678, 4'b0100, 4'b0100, 1'b1,  2};
        vt[3]  = '{1'b0, 4'b0000, 1'b0, 32'h0,         4'b0000, 4'b0000, 1'b0, -1};
        // reset, then all four request continuously: 0,1,2,3,0
        vt[4]  = '{1'b1, 4'b1111, 1'b0, 32'h0,         4'b0000, 4'b0000, 1'b0, -1};
        vt[5]  = '{1'b0, 4'b1111, 1'b0, 32'h0,         4'b0000, 4'b0000, 1'b0, -1};
        vt[6]  = '{1'b0, 4'b1111, 1'b1, 32'h1111_0000, 4'b0001, 4'b0001, 1'b1,  0};
        vt[7]  = '{1'b0, 4'b1111, 1'b0, 32'h0,         4'b0000, 4'b0000, 1'b0, -1};
        vt[8]  = '{1'b0, 4'b1111, 1'b1, 32'h1111_0001, 4'b0010, 4'b0010, 1'b1,  1};
        vt[9]  = '{1'b0, 4'b1111, 1'b0, 32'h0,         4'b0000, 4'b0000, 1'b0, -1};
        vt[10] = '{1'b0, 4'b1111, 1'b1, 32'h1111_0002, 4'b0100, 4'b0100, 1'b1,  2};
        vt[11] = '{1'b0, 4'b1111, 1'b0, 32'h0,         4'b0000, 4'b0000, 1'b0, -1};
        vt[12] = '{1'b0, 4'b1111, 1'b0, 32'h0,         4'b1000, 4'b0000, 1'b1,  3};
        vt[13] = '{1'b0, 4'b1111, 1'b1, 32'h1111_0003, 4'b1000, 4'b1000, 1'b1,  3};
        vt[14] = '{1'b0, 4'b1111, 1'b0, 32'h0,         4'b0000, 4'b0000, 1'b0, -1};
        vt[15] = '{1'b0, 4'b1111, 1'b1, 32'h1111_0004, 4'b0001, 4'b0001, 1'b1,  0};
        vt[16] = '{1'b0, 4'b0000, 1'b0, 32'h0,         4'b0000, 4'b0000, 1'b0, -1};
        // master 1 aborts, pending master 2 served afterwards
        vt[17] = '{1'b0, 4'b0110, 1'b0, 32'h0,         4'b0000, 4'b0000, 1'b0, -1};
        vt[18] = '{1'b0, 4'b0100, 1'b0, 32'h0,         4'b0010, 4'b0000, 1'b0,  1};
        vt[19] = '{1'b0, 4'b0100, 1'b0, 32'h0,         4'b0000, 4'b0000, 1'b0, -1};
        vt[20] = '{1'b0, 4'b0100, 1'b1, 32'h2222_0002, 4'b0100, 4'b0100, 1'b1,  2};
        vt[21] = '{1'b0, 4'b0000, 1'b0, 32'h0,         4'b0000, 4'b0000, 1'b0, -1};
        // reset while master 3 is busy; stray ack after reset is not delivered
        vt[22] = '{1'b0, 4'b1000, 1'b0, 32'h0,         4'b0000, 4'b0000, 1'b0, -1};
        vt[23] = '{1'b1, 4'b1001, 1'b0, 32'h0,         4'b1000, 4'b0000, 1'b1,  3};
        vt[24] = '{1'b0, 4'b1001, 1'b1, 32'h3333_0000, 4'b0000, 4'b0000, 1'b0, -1};
        vt[25] = '{1'b0, 4'b1001, 1'b1, 32'h3333_0001, 4'b0001, 4'b0001, 1'b1,  0};
        // ack and cyc drop in the same cycle for master 0
        vt[26] = '{1'b1, 4'b0000, 1'b0, 32'h0,         4'b0000, 4'b0000, 1'b0, -1};
        vt[27] = '{1'b0, 4'b0011, 1'b0, 32'h0,         4'b0000, 4'b0000, 1'b0, -1};
        vt[28] = '{1'b0, 4'b0010, 1'b1, 32'h4444_0000, 4'b0001, 4'b0001, 1'b0,  0};
        vt[29] = '{1'b0, 4'b0010, 1'b0, 32'h0,         4'b0000, 4'b0000, 1'b0, -1};
        vt[30] = '{1'b0, 4'b0010, 1'b1, 32'h4444_0001, 4'b0010, 4'b0010, 1'b1,  1};
        vt[31] = '{1'b0, 4'b0000, 1'b0, 32'h0,         4'b0000, 4'b0000, 1'b0, -1};

        repeat (2) @(posedge clk);

        // Reset state
        @(negedge clk);
        #1;
        chk_all(-1, 4'b0000, 4'b0000, 1'b0, -1, 32'h0, 1'b0);

        // Table vectors: drive at the falling edge, check just after.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vt[i].rst, vt[i].cyc, vt[i].ack, vt[i].rdat);
            #1;
            chk_all(i, vt[i].e_gnt, vt[i].e_ack, vt[i].e_scyc, vt[i].e_mst, vt[i].rdat, 1'b0);
        end

        // Slave never acks: master 2 (last served was master 1).
        @(negedge clk);
        drive(1'b0, 4'b0100, 1'b0, 32'h5555_AAAA);
        #1;
        chk_all(100, 4'b0000, 4'b0000, 1'b0, -1, 32'h5555_AAAA, 1'b0);
`ifdef WB_ARB_TIMEOUT_EN
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            #1;
            chk_all(200 + j, 4'b0100, 4'b0000, 1'b1, 2, 32'h5555_AAAA, 1'b0);
        end
        @(negedge clk);
        #1;
        chk_all(208, 4'b0100, 4'b0100, 1'b0, 2, 32'hDEAD_BEEF, 1'b1);
        @(negedge clk);
        drive(1'b0, 4'b0000, 1'b0, 32'h5555_AAAA);
        #1;
        chk_all(209, 4'b0000, 4'b0000, 1'b0, -1, 32'h5555_AAAA, 1'b0);
`else
        for (int j = 0; j < 120; j++) begin
            @(negedge clk);
            #1;
            chk("persist_gnt", 200 + j, {28'h0, gnt}, 32'h0000_0004);
            chk("persist_ack", 200 + j, {28'h0, m_ack}, 32'h0);
            chk("persist_tout", 200 + j, {31'h0, tout}, 32'h0);
        end
        @(negedge clk);
        drive(1'b0, 4'b0000, 1'b0, 32'h5555_AAAA);
        #1;
        chk_all(320, 4'b0100, 4'b0000, 1'b0, 2, 32'h5555_AAAA, 1'b0);
        @(negedge clk);
        #1;
        chk_all(321, 4'b0000, 4'b0000, 1'b0, -1, 32'h5555_AAAA, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
